mem_wb_writeback: RTL and testbench

Writeback stage that drives the register-file write port (`reg_write`, `write_reg`, `write_data`, `tick_memwb`). It accepts one retiring instruction per cycle from the MEM stage and waits a variable number of cycles for load data from data memory. It aligns and sign/zero-extends that load data, then issues a single-cycle commit strobe. It sits between the MEM stage / data-memory read port and the register file.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/load_align.sv | 39 +++
 rtl/mem_wb_writeback.sv | 155 +++++++++++++++
 tb/tb_mem_wb_writeback.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings, FSM states and
// the default datapath width.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StWaitMem,
    StCommit,
    StDrain
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load-data aligner: selects the byte/halfword addressed by offset,
// sign/zero-extends it and flags misaligned halfword/word accesses.
module load_align
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    misalign = 1'b0;
    case (funct3)
      F3Lb:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3Lbu:   data = {{(XLEN-8){1'b0}}, byte_sel};
      F3Lh: begin
        data     = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign = offset[0];
      end
      F3Lhu: begin
        data     = {{(XLEN-16){1'b0}}, half_sel};
        misalign = offset[0];
      end
      // LW and unused encodings take the whole word
      default: misalign = (offset != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// Writeback stage: retires one instruction per cycle, waits for load data, aligns it and
// drives a one-cycle register-file commit. Define WB_INSTRET_EN to add the instret counter.
module mem_wb_writeback
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_reg_write,
  input  logic            in_is_load,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_result,
  input  logic            flush,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            reg_write,
  output logic [RA_W-1:0] write_reg,
  output logic [XLEN-1:0] write_data,
  output logic            tick_memwb,
  output logic            misalign
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  wb_state_e state_q, state_d;

  logic [RA_W-1:0] rd_q, rd_d;
  logic            rw_q, rw_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      offset_q, offset_d;

  logic            reg_write_q, reg_write_d;
  logic [RA_W-1:0] write_reg_q, write_reg_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic            tick_q, tick_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] align_data;
  logic            align_mis;
  logic            accept;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3   (funct3_q),
    .offset   (offset_q),
    .rdata    (mem_rdata),
    .data     (align_data),
    .misalign (align_mis)
  );

  assign in_ready = (state_q == StIdle) || (state_q == StCommit);
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    state_d      = state_q;
    rd_d         = rd_q;
    rw_d         = rw_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    tick_d       = 1'b0;
    misalign_d   = 1'b0;
    unique case (state_q)
      StIdle, StCommit: begin
        state_d = StIdle;
        if (accept) begin
          rd_d     = in_rd;
          rw_d     = in_reg_write;
          funct3_d = in_funct3;
          offset_d = in_result[1:0];
          if (in_is_load) begin
            state_d = StWaitMem;
          end else begin
            state_d      = StCommit;
            tick_d       = 1'b1;
            reg_write_d  = in_reg_write && (in_rd != '0);
            write_reg_d  = in_rd;
            write_data_d = in_result;
          end
        end
      end
      StWaitMem: begin
        if (mem_rvalid && flush) begin
          state_d = StIdle;
        end else if (mem_rvalid) begin
          state_d      = StCommit;
          tick_d       = 1'b1;
          misalign_d   = align_mis;
          reg_write_d  = rw_q && (rd_q != '0) && !align_mis;
          write_reg_d  = rd_q;
          write_data_d = align_data;
        end else if (flush) begin
          // Read is still outstanding; its data must be swallowed
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      funct3_q     <= '0;
      offset_q     <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      tick_q       <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_q         <= rd_d;
      rw_q         <= rw_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      tick_q       <= tick_d;
      misalign_q   <= misalign_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign tick_memwb = tick_q;
  assign misalign   = misalign_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (tick_d) instret_q <= instret_q + 64'd1;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: directed scenarios plus randomized retire
// traffic checked against a behavioural load/commit model.
module tb_mem_wb_writeback;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [RA_W-1:0] in_rd = '0;
  logic            in_reg_write = 1'b0;
  logic            in_is_load = 1'b0;
  logic [2:0]      in_funct3 = '0;
  logic [XLEN-1:0] in_result = '0;
  logic            flush = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            reg_write;
  logic [RA_W-1:0] write_reg;
  logic [XLEN-1:0] write_data;
  logic            tick_memwb;
  logic            misalign;
`ifdef WB_INSTRET_EN
  logic [63:0]     instret;
`endif

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_instret = '0;

  always #5 clk = ~clk;

  mem_wb_writeback #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .in_is_load   (in_is_load),
    .in_funct3    (in_funct3),
    .in_result    (in_result),
    .flush        (flush),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .tick_memwb   (tick_memwb),
    .misalign     (misalign)
`ifdef WB_INSTRET_EN
    ,
    .instret      (instret)
`endif
  );

  // Reference load result computed arithmetically from the word and byte offset
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * int'(off))) & 32'h0000_00FF;
    h = (w >> (16 * int'(off[1]))) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'b001 || f3 == 3'b101) return off[0];
    if (f3 == 3'b010) return off != 2'b00;
    return 1'b0;
  endfunction

  // Non-load retire; entered and left just after a falling edge
  task automatic do_alu(input logic [RA_W-1:0] rd, input logic rw, input logic [31:0] res);
    logic exp_rw;
    exp_rw = rw && (rd != 0);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL alu_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b1; in_rd = rd; in_reg_write = rw; in_is_load = 1'b0;
    in_funct3 = 3'($urandom); in_result = res;
    @(negedge clk);
    in_valid = 1'b0;
    exp_instret++;
    total++;
    if (tick_memwb !== 1'b1 || reg_write !== exp_rw || write_reg !== rd ||
        write_data !== res || misalign !== 1'b0) begin
      bad++;
      $display("FAIL alu_commit: got tick=%b rw=%b reg=%0d data=%h mis=%b want 1 %b %0d %h 0",
               tick_memwb, reg_write, write_reg, write_data, misalign, exp_rw, rd, res);
    end
`ifdef WB_INSTRET_EN
    total++;
    if (instret !== exp_instret) begin
      bad++;
      $display("FAIL alu_instret: got %0d want %0d", instret, exp_instret);
    end
`endif
  endtask

  // Load retire with read data returned 'delay' cycles after the accept cycle
  task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w,
                         input int delay, input logic [RA_W-1:0] rd, input logic rw);
    logic        exp_mis;
    logic        exp_rw;
    logic [31:0] exp_data;
    exp_mis  = ref_mis(f3, off);
    exp_rw   = rw && (rd != 0) && !exp_mis;
    exp_data = ref_load(f3, off, w);
    in_valid = 1'b1; in_rd = rd; in_reg_write = rw; in_is_load = 1'b1;
    in_funct3 = f3; in_result = {30'($urandom), off};
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0;
    for (int c = 1; c <= delay; c++) begin
      total++;
      if (in_ready !== 1'b0 || tick_memwb !== 1'b0) begin
        bad++;
        $display("FAIL load_wait: cycle %0d got ready=%b tick=%b want 0 0",
                 c, in_ready, tick_memwb);
      end
      mem_rvalid = (c == delay);
      mem_rdata  = (c == delay) ? w : $urandom;
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    exp_instret++;
    total++;
    if (tick_memwb !== 1'b1 || reg_write !== exp_rw || write_reg !== rd ||
        misalign !== exp_mis || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_commit: got tick=%b rw=%b reg=%0d mis=%b rdy=%b want 1 %b %0d %b 1",
               tick_memwb, reg_write, write_reg, misalign, in_ready, exp_rw, rd, exp_mis);
    end
    if (!exp_mis) begin
      total++;
      if (write_data !== exp_data) begin
        bad++;
        $display("FAIL load_data: f3=%b off=%0d got %h want %h", f3, off, write_data, exp_data);
      end
    end
`ifdef WB_INSTRET_EN
    total++;
    if (instret !== exp_instret) begin
      bad++;
      $display("FAIL load_instret: got %0d want %0d", instret, exp_instret);
    end
`endif
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    total++;
    if (tick_memwb !== 1'b0 || reg_write !== 1'b0 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL idle: got tick=%b rw=%b mis=%b want 0 0 0", tick_memwb, reg_write, misalign);
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (reg_write !== 1'b0 || write_reg !== '0 || write_data !== '0 ||
        tick_memwb !== 1'b0 || misalign !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rw=%b reg=%0d data=%h tick=%b mis=%b want zeros",
               reg_write, write_reg, write_data, tick_memwb, misalign);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
`ifdef WB_INSTRET_EN
    total++;
    if (instret !== 64'd0) begin
      bad++;
      $display("FAIL reset_instret: got %0d want 0", instret);
    end
`endif
  endtask

  task automatic test_add_retire();
    do_alu(5'd5, 1'b1, 32'h0000_002A);
    idle_cycle();
    total++;
    if (write_data !== 32'h0000_002A || write_reg !== 5'd5) begin
      bad++;
      $display("FAIL add_hold: got reg=%0d data=%h want 5 0000002a", write_reg, write_data);
    end
    do_alu(5'd0, 1'b1, 32'h1234_5678);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) do_alu(5'($urandom), 1'($urandom), $urandom);
    idle_cycle();
  endtask

  task automatic test_load_ext();
    do_load(3'b000, 2'd3, 32'h80FF_1234, 1, 5'd3, 1'b1);
    total++;
    if (write_data !== 32'hFFFF_FF80) begin
      bad++;
      $display("FAIL lb_sign: got %h want ffffff80", write_data);
    end
    do_load(3'b100, 2'd3, 32'h80FF_1234, 2, 5'd4, 1'b1);
    total++;
    if (write_data !== 32'h0000_0080) begin
      bad++;
      $display("FAIL lbu_zero: got %h want 00000080", write_data);
    end
    do_load(3'b101, 2'd2, 32'h80FF_1234, 1, 5'd6, 1'b1);
    total++;
    if (write_data !== 32'h0000_80FF) begin
      bad++;
      $display("FAIL lhu_hi: got %h want 000080ff", write_data);
    end
    idle_cycle();
  endtask

  task automatic test_load_wait();
    do_load(3'b010, 2'd0, 32'hDEAD_BEEF, 4, 5'd9, 1'b1);
    idle_cycle();
  endtask

  task automatic test_misalign();
    do_load(3'b010, 2'd1, 32'hCAFE_F00D, 2, 5'd7, 1'b1);
    total++;
    if (misalign !== 1'b1 || reg_write !== 1'b0) begin
      bad++;
      $display("FAIL lw_misalign: got mis=%b rw=%b want 1 0", misalign, reg_write);
    end
    do_load(3'b001, 2'd3, 32'hCAFE_F00D, 1, 5'd8, 1'b1);
    idle_cycle();
  endtask

  task automatic test_flush();
    // Flush while waiting, data arrives three cycles later
    in_valid = 1'b1; in_rd = 5'd11; in_reg_write = 1'b1; in_is_load = 1'b1;
    in_funct3 = 3'b010; in_result = 32'h100;
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0; flush = 1'b1;
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      flush = 1'b0;
      mem_rvalid = (c == 5);
      mem_rdata = 32'h5555_AAAA;
      total++;
      if (in_ready !== 1'b0 || tick_memwb !== 1'b0) begin
        bad++;
        $display("FAIL flush_drain: cycle %0d got rdy=%b tick=%b want 0 0", c, in_ready, tick_memwb);
      end
    end
    @(negedge clk);
    mem_rvalid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || tick_memwb !== 1'b0) begin
      bad++;
      $display("FAIL flush_return: got rdy=%b tick=%b want 1 0", in_ready, tick_memwb);
    end
    idle_cycle();
    // Flush and data in the same cycle
    in_valid = 1'b1; in_is_load = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0; flush = 1'b1; mem_rvalid = 1'b1;
    @(negedge clk);
    flush = 1'b0; mem_rvalid = 1'b0;
    total++;
    if (in_ready !== 1'b1 || tick_memwb !== 1'b0) begin
      bad++;
      $display("FAIL flush_same: got rdy=%b tick=%b want 1 0", in_ready, tick_memwb);
    end
    // Flush blocks an accept in IDLE
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    total++;
    if (tick_memwb !== 1'b0) begin
      bad++;
      $display("FAIL flush_block: got tick=%b want 0", tick_memwb);
    end
    idle_cycle();
  endtask

  task automatic test_async_reset();
    do_alu(5'd9, 1'b1, 32'h0BAD_F00D);
    in_valid = 1'b1; in_rd = 5'd12; in_reg_write = 1'b1; in_is_load = 1'b1;
    in_funct3 = 3'b010; in_result = 32'h0;
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_instret = '0;
    #1;
    total++;
    if (reg_write !== 1'b0 || write_reg !== '0 || write_data !== '0 ||
        tick_memwb !== 1'b0 || misalign !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got rw=%b reg=%0d data=%h tick=%b mis=%b rdy=%b want 0s rdy=1",
               reg_write, write_reg, write_data, tick_memwb, misalign, in_ready);
    end
`ifdef WB_INSTRET_EN
    total++;
    if (instret !== 64'd0) begin
      bad++;
      $display("FAIL async_instret: got %0d want 0", instret);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    total++;
    if (tick_memwb !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stale_rvalid: got tick=%b rdy=%b want 0 1", tick_memwb, in_ready);
    end
  endtask

  task automatic test_random();
    logic [2:0] f3s [5];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_alu(5'($urandom), 1'($urandom), $urandom);
      end else begin
        do_load(f3s[$urandom_range(0, 4)], 2'($urandom), $urandom,
                int'($urandom_range(1, 5)), 5'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_add_retire();
    test_back_to_back();
    test_load_ext();
    test_load_wait();
    test_misalign();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
